// File: rtl/prbs_pkg.sv
// Shared PRBS11 definitions: polynomial x^11 + x^9 + 1 and the checker FSM encoding.
package prbs_pkg;

  localparam int PRBS11_WIDTH = 11;
  localparam int TAP_A        = 9;
  localparam int TAP_B        = 11;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

endpackage

// File: rtl/prbs11_checker.sv
// Self-synchronising PRBS11 checker: fills history, searches for a run of correct
// predictions, then flywheels on its own prediction and monitors errors per window.
module prbs11_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        cnt_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam logic [1:0] FILL   = ST_FILL;
  localparam logic [1:0] SEARCH = ST_SEARCH;
  localparam logic [1:0] LOCKED = ST_LOCKED;

  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int WB = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE = $clog2(LOSS_THRESH + 1);

  logic [1:0]              state;
  logic [PRBS11_WIDTH:1]   h;
  logic [3:0]              fill_cnt;
  logic [MW-1:0]           match_cnt;
  logic [WB-1:0]           win_bits;
  logic [WE-1:0]           win_errs;

  logic predicted;
  logic mismatch;
  logic h_zero;

  assign predicted = h[TAP_A] ^ h[TAP_B];
  assign mismatch  = in_bit ^ predicted;
  assign h_zero    = (h == '0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= FILL;
      h         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (cnt_clr) err_count <= '0;
      if (in_valid) begin
        case (state)
          FILL: begin
            h <= {h[PRBS11_WIDTH-1:1], in_bit};
            if (fill_cnt == 4'(PRBS11_WIDTH - 1)) begin
              state     <= SEARCH;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 4'd1;
            end
          end
          SEARCH: begin
            h <= {h[PRBS11_WIDTH-1:1], in_bit};
            // An all-zero history predicts zero forever, so it never counts as a match.
            if (!mismatch && !h_zero) begin
              if (match_cnt == MW'(LOCK_THRESH - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: history advances on the prediction, not the received bit.
            h <= {h[PRBS11_WIDTH-1:1], predicted};
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (!cnt_clr && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (mismatch && win_errs == WE'(LOSS_THRESH - 1)) begin
              state    <= FILL;
              locked   <= 1'b0;
              fill_cnt <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else if (win_bits == WB'(WINDOW - 1)) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + WB'(1);
              if (mismatch) win_errs <= win_errs + WE'(1);
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: doc/prbs11_checker.md
PRBS11_CHECKER -- requirements
Module: prbs11_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter WINDOW, default 64: valid bits per error-monitoring window while locked.
REQ-003 Parameter LOSS_THRESH, default 8: errors within one window that force loss of lock.
REQ-004 clock  input  1: single clock; all state changes on its rising edge.
REQ-005 clear  input  1: asynchronous, active-low reset.
REQ-006 in_bit  input  1: serial bit from the upstream 11-bit Fibonacci LFSR (x^11 + x^9 + 1).
REQ-007 in_valid  input  1: in_bit is sampled only when high; when low, no state changes.
REQ-008 cnt_clr  input  1: synchronous clear of err_count; does not affect lock state.
REQ-009 locked  output  1: checker is synchronised to the sequence.
REQ-010 err_pulse  output  1: one-cycle pulse per detected bit error while locked.
REQ-011 err_count  output  16: total errors detected while locked; saturates at 65535.

Function
REQ-012 History register h[11:1] shall hold past bits, h[1] newest; each accepted bit shifts h[k+1]<=h[k].
REQ-013 Predicted bit p = h[9] XOR h[11], since s(n) = s(n-9) XOR s(n-11).
REQ-014 FSM states: FILL, SEARCH, LOCKED; reset state FILL.
REQ-015 FILL: h[1]<=in_bit on each valid bit; after the 11th valid bit, go to SEARCH with match count 0.
REQ-016 SEARCH: compare in_bit with p, then h[1]<=in_bit (self-synchronising).
REQ-017 SEARCH match with h != 0: match count +1; mismatch or h == 0: match count reset to 0.
REQ-018 The match that brings the count to LOCK_THRESH moves the FSM to LOCKED; locked is high from the next edge onward.
REQ-019 LOCKED: h[1]<=p (flywheel), so received errors never corrupt the history.
REQ-020 LOCKED mismatch: err_pulse high for exactly the cycle after the sampling edge; err_count +1 unless already 65535.
REQ-021 Window bit count runs 0..WINDOW-1 over valid bits in LOCKED; at wrap, window bit count and window error count both return to 0.
REQ-022 A mismatch that brings the window error count to LOSS_THRESH moves the FSM to FILL and clears locked, fill count and window counters, on the same edge; that error still pulses and counts.
REQ-023 Loss of lock takes priority over window wrap on the same bit.
REQ-024 cnt_clr and an error on the same edge: err_count becomes 0 (clear wins); err_pulse still asserts.
REQ-025 An all-zero stream shall never produce lock (REQ-017 h==0 rule).
REQ-026 in_valid low in any state holds all counters, h, FSM and err_count; err_pulse is low.

Reset
REQ-027 clear low asynchronously forces FSM=FILL, h=0, all counters=0, locked=0, err_pulse=0, err_count=0.
REQ-028 Reset mid-lock discards synchronisation; re-lock requires a full FILL and SEARCH sequence after release.

Structure
REQ-029 Shared package prbs_pkg: PRBS11_WIDTH=11, tap positions 9 and 11, FSM state enum, shared by generator and checker benches.
REQ-030 Single flat module; no sub-module (prediction is one XOR, and counters are local).

Verification
REQ-031 LFSR seeded 11'd2047 drives in_bit with in_valid=1 continuously -> locked rises after 27th valid bit (11 fill + 16 matches), err_count=0 over 5000 bits.
REQ-032 Locked, invert one bit -> err_pulse exactly 1 cycle, err_count=1, locked stays high, next 100 bits error-free.
REQ-033 Locked, invert 8 bits within one 64-bit window -> locked falls after 8th error, err_count=8; re-locks 27 valid bits later.
REQ-034 in_bit=0 for 500 valid cycles -> locked never asserts, err_count=0.
REQ-035 Random in_valid gaps (50% duty) on the REQ-031 stream -> lock on the same 27th valid bit, no errors.
REQ-036 clear pulsed low mid-lock (non-aligned to clock) -> locked, err_pulse, err_count zero immediately; REQ-031 timing repeats after release.
